pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Purpose: hazard/stall/flush controller for a five-stage in-order pipeline.
// Latency: stage enables and flushes are combinational from state and current inputs; state and counters update on the next stg_clk edge.
// Backpressure: a pending memory access (mem_req & ~mem_ready) freezes every stage until mem_ready rises.
module pipeline_ctrl (
  input  logic        stg_clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rd_memory,
  input  logic        ex_save_to_reg,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_ena,
  output logic        if_id_ena,
  output logic        id_ex_ena,
  output logic        if_id_x,
  output logic        id_ex_x,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [7:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } ctrl_state_t;

  ctrl_state_t state_q;
  ctrl_state_t state_nxt;

  logic freeze;
  logic branch;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use_raw;
  logic load_use;
  logic flush_accept;

  assign state = state_q;

  // Hazard conditions. A load to x0 never produces a value, so it never stalls.
  // The load-use check is masked while execute already holds the bubble
  // (LOAD_STALL) and while the fetch redirect is still draining (FLUSH).
  always_comb begin
    freeze       = mem_req & ~mem_ready;
    branch       = ex_branch_taken;
    rs1_hit      = id_rs1_used & (id_rs1 == ex_rd);
    rs2_hit      = id_rs2_used & (id_rs2 == ex_rd);
    load_use_raw = id_valid & ex_rd_memory & ex_save_to_reg & (ex_rd != 5'd0) &
                   (rs1_hit | rs2_hit);
    load_use     = load_use_raw & (state_q != ST_LOAD_STALL) & (state_q != ST_FLUSH);
    flush_accept = branch & ~freeze & ~reset;
  end

  // State register; reset abandons any stall, flush or freeze in progress.
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state: freeze beats branch beats load-use, identically in every state.
  // A branch held in execute across a freeze is picked up on the exit cycle
  // because execute is frozen and keeps presenting it.
  always_comb begin
    state_nxt = ST_RUN;
    if (freeze) begin
      state_nxt = ST_MEM_WAIT;
    end else if (branch) begin
      state_nxt = ST_FLUSH;
    end else if (load_use) begin
      state_nxt = ST_LOAD_STALL;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  // Stage enables and flushes; all quiet while reset is asserted.
  // FLUSH keeps if_id_x high one extra cycle to kill the fetch that was
  // already in flight in the 1-cycle instruction memory.
  always_comb begin
    pc_ena    = 1'b1;
    if_id_ena = 1'b1;
    id_ex_ena = 1'b1;
    if_id_x   = 1'b0;
    id_ex_x   = 1'b0;
    if (reset) begin
      pc_ena    = 1'b0;
      if_id_ena = 1'b0;
      id_ex_ena = 1'b0;
    end else if (freeze) begin
      pc_ena    = 1'b0;
      if_id_ena = 1'b0;
      id_ex_ena = 1'b0;
    end else if (branch) begin
      if_id_x   = 1'b1;
      id_ex_x   = 1'b1;
    end else if (load_use) begin
      pc_ena    = 1'b0;
      if_id_ena = 1'b0;
      id_ex_x   = 1'b1;
    end else begin
      if_id_x   = (state_q == ST_FLUSH);
    end
  end

  // Counts cycles in which the PC did not advance, saturating.
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (!pc_ena && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Counts taken branches actually acted on (not those held under a freeze), saturating.
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      flush_cnt <= 8'd0;
    end else if (flush_accept && (flush_cnt != 8'hFF)) begin
      flush_cnt <= flush_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, branches, freezes, async reset, counter saturation.
// Expected values per cycle are pushed to a scoreboard queue and popped at the check points.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
module tb_pipeline_ctrl;

  logic        stg_clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  ex_rd;
  logic        ex_rd_memory;
  logic        ex_save_to_reg;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_ena;
  logic        if_id_ena;
  logic        id_ex_ena;
  logic        if_id_x;
  logic        id_ex_x;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [7:0]  flush_cnt;

  int vectors;
  int miscompares;

  typedef struct {
    string       tag;
    logic [4:0]  outs;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [7:0]  fc;
  } exp_t;

  exp_t sb[$];

  // {pc_ena, if_id_ena, id_ex_ena, if_id_x, id_ex_x}
  localparam logic [4:0] O_NORM = 5'b11100;
  localparam logic [4:0] O_LOAD = 5'b00101;
  localparam logic [4:0] O_BR   = 5'b11111;
  localparam logic [4:0] O_FRZ  = 5'b00000;
  localparam logic [4:0] O_FL2  = 5'b11110;

  pipeline_ctrl dut (
    .stg_clk         (stg_clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_rd           (ex_rd),
    .ex_rd_memory    (ex_rd_memory),
    .ex_save_to_reg  (ex_save_to_reg),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_ena          (pc_ena),
    .if_id_ena       (if_id_ena),
    .id_ex_ena       (id_ex_ena),
    .if_id_x         (if_id_x),
    .id_ex_x         (id_ex_x),
    .state           (state),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial begin
    stg_clk = 1'b0;
    forever #5 stg_clk = ~stg_clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rd = 0; ex_rd_memory = 0; ex_save_to_reg = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  // Load in EX writing rd, ID reading rs1 (and/or rs2).
  task automatic load_use(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2);
    idle();
    id_valid = 1; ex_rd_memory = 1; ex_save_to_reg = 1; ex_rd = rd;
    id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
  endtask

  // One clock cycle: expected outputs this cycle, state/counters after the edge.
  task automatic cyc(input string tag, input logic [4:0] eo, input logic [1:0] es,
                     input logic [15:0] esc, input logic [7:0] efc);
    exp_t e;
    e.tag = tag; e.outs = eo; e.st = es; e.sc = esc; e.fc = efc;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".outs"}, {11'd0, pc_ena, if_id_ena, id_ex_ena, if_id_x, id_ex_x}, {11'd0, e.outs});
    @(posedge stg_clk); #1;
    chk({e.tag, ".state"}, {14'd0, state}, {14'd0, e.st});
    chk({e.tag, ".stall"}, stall_cnt, e.sc);
    chk({e.tag, ".flush"}, {8'd0, flush_cnt}, {8'd0, e.fc});
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    idle();
    reset = 1;
    #2;
    chk("rst.outs", {11'd0, pc_ena, if_id_ena, id_ex_ena, if_id_x, id_ex_x}, 16'd0);
    chk("rst.state", {14'd0, state}, 16'd0);
    chk("rst.stall", stall_cnt, 16'd0);
    chk("rst.flush", {8'd0, flush_cnt}, 16'd0);
    @(posedge stg_clk); #1;
    reset = 0;

    idle();                    cyc("idle",     O_NORM, 2'd0, 16'd0, 8'd0);
    load_use(5, 5, 1, 0, 0);   cyc("lu_rs1",   O_LOAD, 2'd1, 16'd1, 8'd0);
                               cyc("lu_mask",  O_NORM, 2'd0, 16'd1, 8'd0);
    load_use(0, 0, 1, 0, 1);   cyc("lu_x0",    O_NORM, 2'd0, 16'd1, 8'd0);
    load_use(5, 5, 0, 0, 0);   cyc("lu_unused",O_NORM, 2'd0, 16'd1, 8'd0);
    load_use(7, 3, 1, 7, 1);   cyc("lu_rs2",   O_LOAD, 2'd1, 16'd2, 8'd0);
    idle();                    cyc("idle2",    O_NORM, 2'd0, 16'd2, 8'd0);
    load_use(5, 5, 1, 0, 0); ex_save_to_reg = 0;
                               cyc("lu_nowb",  O_NORM, 2'd0, 16'd2, 8'd0);
    load_use(5, 5, 1, 0, 0); id_valid = 0;
                               cyc("lu_novld", O_NORM, 2'd0, 16'd2, 8'd0);

    idle(); ex_branch_taken = 1; cyc("br",     O_BR,   2'd2, 16'd2, 8'd1);
    idle();                    cyc("br_fl2",   O_FL2,  2'd0, 16'd2, 8'd1);
    idle();                    cyc("br_run",   O_NORM, 2'd0, 16'd2, 8'd1);

    idle(); ex_branch_taken = 1; cyc("br2",    O_BR,   2'd2, 16'd2, 8'd2);
    load_use(9, 9, 1, 0, 0);   cyc("fl_lumask",O_FL2,  2'd0, 16'd2, 8'd2);
    load_use(9, 9, 1, 0, 0);   cyc("lu_run",   O_LOAD, 2'd1, 16'd3, 8'd2);
    idle();                    cyc("idle3",    O_NORM, 2'd0, 16'd3, 8'd2);

    idle(); ex_branch_taken = 1; mem_req = 1;
    cyc("frz1", O_FRZ, 2'd3, 16'd4, 8'd2);
    cyc("frz2", O_FRZ, 2'd3, 16'd5, 8'd2);
    cyc("frz3", O_FRZ, 2'd3, 16'd6, 8'd2);
    mem_ready = 1;             cyc("frz_exbr", O_BR,   2'd2, 16'd6, 8'd3);
    idle();                    cyc("frz_fl2",  O_FL2,  2'd0, 16'd6, 8'd3);

    idle(); mem_req = 1;       cyc("frz_lu1",  O_FRZ,  2'd3, 16'd7, 8'd3);
    load_use(4, 0, 0, 4, 1); mem_req = 1; mem_ready = 1;
                               cyc("frz_exlu", O_LOAD, 2'd1, 16'd8, 8'd3);
    idle(); mem_req = 1; mem_ready = 1;
                               cyc("memrdy",   O_NORM, 2'd0, 16'd8, 8'd3);
    idle(); ex_branch_taken = 1; cyc("br3",    O_BR,   2'd2, 16'd8, 8'd4);
    idle(); mem_req = 1;       cyc("fl_frz",   O_FRZ,  2'd3, 16'd9, 8'd4);
    idle();                    cyc("fl_frzx",  O_NORM, 2'd0, 16'd9, 8'd4);

    // Asynchronous reset in the middle of a freeze.
    idle(); mem_req = 1;       cyc("pre_rst",  O_FRZ,  2'd3, 16'd10, 8'd4);
    #2;
    reset = 1;
    #1;
    chk("arst.outs", {11'd0, pc_ena, if_id_ena, id_ex_ena, if_id_x, id_ex_x}, 16'd0);
    chk("arst.state", {14'd0, state}, 16'd0);
    chk("arst.stall", stall_cnt, 16'd0);
    chk("arst.flush", {8'd0, flush_cnt}, 16'd0);
    @(posedge stg_clk); #1;
    reset = 0;
    idle();                    cyc("post_rst", O_NORM, 2'd0, 16'd0, 8'd0);

    // Stall counter saturation under a long freeze.
    idle(); mem_req = 1;
    for (int i = 1; i <= 70000; i++) begin
      @(posedge stg_clk); #1;
      if (i == 65534) chk("sat.stall_fffe", stall_cnt, 16'hFFFE);
      if (i == 65535) chk("sat.stall_ffff", stall_cnt, 16'hFFFF);
    end
    chk("sat.stall_hold", stall_cnt, 16'hFFFF);
    chk("sat.state_mw", {14'd0, state}, 16'd3);

    // Flush counter saturation under back-to-back branches.
    idle(); ex_branch_taken = 1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge stg_clk); #1;
      if (i == 254) chk("sat.flush_fe", {8'd0, flush_cnt}, 16'h00FE);
      if (i == 255) chk("sat.flush_ff", {8'd0, flush_cnt}, 16'h00FF);
    end
    chk("sat.flush_hold", {8'd0, flush_cnt}, 16'h00FF);
    chk("sat.state_fl", {14'd0, state}, 16'd2);
    chk("sat.stall_keep", stall_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
